// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_conv_arbiter
//  Description : Round-robin arbiter that shares one binary-to-Gray converter
//                among NREQ requesters. One request is accepted per cycle, and
//                the result is held in a single-entry valid/ready output
//                register.
//  Revision    : 1.0  initial release
// ============================================================================
module gray_conv_arbiter #(
   parameter  int WIDTH = 4,
   parameter  int NREQ  = 4,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] bin_in,
   output logic [NREQ-1:0]       gnt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_gray,
   output logic [WIDTH-1:0]      out_bin,
   output logic [IDW-1:0]        out_id
);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDW-1:0]   last;
   logic             can_issue;
   logic             found;
   logic             grant;
   logic [NREQ-1:0]  pick_onehot;
   logic [IDW-1:0]   pick_idx;
   logic [WIDTH-1:0] sel_bin;
   logic [WIDTH-1:0] sel_gray;

   assign out_valid = (state == FULL);

   // The output slot can take a new result when it is empty or being drained.
   assign can_issue = (state == EMPTY) | (out_valid & out_ready);

   // Search upward from the slot after the last winner, wrapping modulo NREQ.
   always_comb begin
      int cand;
      pick_onehot = '0;
      pick_idx    = '0;
      found       = 1'b0;
      cand        = 0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = (int'(last) + i) % NREQ;
         if (!found && req[cand]) begin
            found             = 1'b1;
            pick_idx          = IDW'(cand);
            pick_onehot[cand] = 1'b1;
         end
      end
   end

   // A grant is only issued out of reset, with room in the slot and a winner.
   assign grant = rst_n & can_issue & found;
   assign gnt   = grant ? pick_onehot : '0;

   assign sel_bin  = bin_in[int'(pick_idx)*WIDTH +: WIDTH];
   // Bitwise conversion: each Gray bit is the XOR of neighbouring binary bits.
   assign sel_gray = sel_bin ^ (sel_bin >> 1);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: a grant always fills the slot; a drain without a grant empties it.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (grant) begin
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (grant) begin
               state_nxt = FULL;
            end else if (out_ready) begin
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Result registers and round-robin pointer load only on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_gray <= '0;
         out_bin  <= '0;
         out_id   <= '0;
         last     <= IDW'(NREQ - 1);
      end else if (grant) begin
         out_gray <= sel_gray;
         out_bin  <= sel_bin;
         out_id   <= pick_idx;
         last     <= pick_idx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_conv_arbiter
//  Description : Self-checking bench for gray_conv_arbiter with a behavioural
//                model, directed cases and randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_conv_arbiter;

   localparam int W   = 4;
   localparam int N   = 4;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] bin_in;
   logic [N-1:0]   gnt;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_gray;
   logic [W-1:0]   out_bin;
   logic [IDW-1:0] out_id;

   gray_conv_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .bin_in    (bin_in),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_gray  (out_gray),
      .out_bin   (out_bin),
      .out_id    (out_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model of the output slot and round-robin pointer.
   bit           m_valid;
   logic [W-1:0] m_gray;
   logic [W-1:0] m_bin;
   int           m_id;
   int           m_last;
   logic [N-1:0] g_obs;

   logic [3:0] exp_seq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
   logic [3:0] rr_seq [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int i = 1; i <= N; i++) begin
         if (r[(last + i) % N]) return (last + i) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_gray  = '0;
      m_bin   = '0;
      m_id    = 0;
      m_last  = N - 1;
   endtask

   // Entered just after a rising edge with inputs already driven; compares the
   // DUT against the model mid-cycle, then advances the model across the edge.
   task automatic step();
      int           k;
      bit           can;
      logic [N-1:0] eg;
      #2;
      k   = pick(req, m_last);
      can = !m_valid || out_ready;
      eg  = (can && k >= 0) ? N'(1 << k) : '0;
      g_obs = gnt;
      check("gnt", 32'(gnt), 32'(eg));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         check("out_gray", 32'(out_gray), 32'(m_gray));
         check("out_bin", 32'(out_bin), 32'(m_bin));
         check("out_id", 32'(out_id), 32'(m_id));
      end
      @(posedge clk);
      if (eg != '0) begin
         m_valid = 1'b1;
         m_bin   = bin_in[k*W +: W];
         m_gray  = m_bin ^ (m_bin >> 1);
         m_id    = k;
         m_last  = k;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      req = 4'b1010;
      #1;
      check("rst_gnt_zero", 32'(gnt), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      req = '0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0] r;
      rst_n     = 1'b0;
      req       = 4'b0001;
      bin_in    = '0;
      out_ready = 1'b0;
      model_reset();
      g_obs = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_gnt", 32'(gnt), 32'h0);
      check("reset_valid", 32'(out_valid), 32'h0);
      check("reset_gray", 32'(out_gray), 32'h0);
      check("reset_bin", 32'(out_bin), 32'h0);
      check("reset_id", 32'(out_id), 32'h0);
      req = '0;
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: single request
      req = 4'b0001; bin_in[0 +: W] = 4'b1011; out_ready = 1'b1;
      step();
      check("t1_gnt", 32'(g_obs), 32'b0001);
      check("t1_valid", 32'(out_valid), 32'h1);
      check("t1_gray", 32'(out_gray), 32'b1110);
      check("t1_bin", 32'(out_bin), 32'b1011);
      check("t1_id", 32'(out_id), 32'h0);

      // 2: exhaustive conversion through requester 2
      for (int v = 0; v < 16; v++) begin
         req = 4'b0100; bin_in[2*W +: W] = W'(v);
         step();
         check("t2_gray", 32'(out_gray), 32'(exp_seq[v]));
         check("t2_id", 32'(out_id), 32'h2);
      end

      // 3: round robin with all requesters held, starting from reset
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req = 4'b1111;
         for (int k = 0; k < N; k++) bin_in[k*W +: W] = W'(k + 3 * i);
         step();
         check("t3_gnt", 32'(g_obs), 32'(rr_seq[i]));
         check("t3_valid", 32'(out_valid), 32'h1);
      end

      // 4: backpressure
      req = '0; step();
      req = 4'b0001; bin_in[0 +: W] = 4'b0110; step();
      check("t4_gray", 32'(out_gray), 32'b0101);
      bin_in[0 +: W] = 4'b0011; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t4_hold_gnt", 32'(g_obs), 32'h0);
         check("t4_hold_gray", 32'(out_gray), 32'b0101);
      end
      out_ready = 1'b1;
      step();
      check("t4_resume_gnt", 32'(g_obs), 32'b0001);
      check("t4_new_gray", 32'(out_gray), 32'b0010);

      // 5: drain to empty, then a ready with nothing held
      req = '0;
      step();
      check("t5_empty", 32'(out_valid), 32'h0);
      step();
      check("t5_still_empty", 32'(out_valid), 32'h0);
      check("t5_data_kept", 32'(out_gray), 32'b0010);

      // 6: reset mid-operation
      req = 4'b1000; bin_in[3*W +: W] = 4'b1111; out_ready = 1'b0;
      step();
      check("t6_gray", 32'(out_gray), 32'b1000);
      check("t6_valid", 32'(out_valid), 32'h1);
      #3;
      do_reset();
      req = 4'b1010; out_ready = 1'b1;
      step();
      check("t6_first_gnt", 32'(g_obs), 32'b0010);

      // Randomized traffic: requesters hold until granted, may drop occasionally.
      for (int c = 0; c < 3000; c++) begin
         r = req;
         for (int k = 0; k < N; k++) begin
            if (g_obs[k]) r[k] = 1'b0;
            if (r[k]) begin
               if ($urandom_range(15) == 0) r[k] = 1'b0;
            end else if ($urandom_range(1) == 1) begin
               r[k] = 1'b1;
               bin_in[k*W +: W] = W'($urandom);
            end
         end
         req       = r;
         out_ready = ($urandom_range(3) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
